// File: rtl/tri_root_hlsm.sv
// Triangular-root HLSM: finds the smallest n with n(n-1)/2 >= t by stepping i and a running sum.
// Optional feature macro: TRI_ROOT_EXACT_EN adds the 'exact' output (sum hit t exactly).
module tri_root_hlsm #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             b,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] n_out,
    output logic             busy,
`ifdef TRI_ROOT_EXACT_EN
    output logic             exact,
`endif
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10,
        S_ILL  = 2'b11
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_i;
    logic [2*WIDTH-1:0]   r_sum;
    logic [WIDTH-1:0]     r_t;
    logic [WIDTH-1:0]     r_n_out;
    logic                 r_busy;
    logic                 r_done;

    logic [2*WIDTH-1:0]   w_t_ext;
    logic [2*WIDTH-1:0]   w_sum_next;
    logic [WIDTH-1:0]     w_i_next;
    logic                 w_sum_ge;

    // Datapath primitives: zero-extend, adder, incrementor, comparator.
    assign w_t_ext    = {{WIDTH{1'b0}}, r_t};
    assign w_sum_next = r_sum + {{WIDTH{1'b0}}, r_i};
    assign w_i_next   = r_i + {{(WIDTH-1){1'b0}}, 1'b1};
    assign w_sum_ge   = (r_sum >= w_t_ext);

`ifdef TRI_ROOT_EXACT_EN
    logic r_exact;
    logic w_sum_eq;

    assign w_sum_eq = (r_sum == w_t_ext);
    assign exact    = r_exact;
`endif

    assign n_out = r_n_out;
    assign busy  = r_busy;
    assign done  = r_done;

    // Controller and datapath registers; busy/done are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_i     <= {WIDTH{1'b0}};
            r_sum   <= {(2*WIDTH){1'b0}};
            r_t     <= {WIDTH{1'b0}};
            r_n_out <= {WIDTH{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef TRI_ROOT_EXACT_EN
            r_exact <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_i    <= {WIDTH{1'b0}};
                    r_sum  <= {(2*WIDTH){1'b0}};
                    r_done <= 1'b0;
                    if (b) begin
                        r_t     <= t;
                        r_state <= S_CALC;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_CALC: begin
                    if (w_sum_ge) begin
                        r_n_out <= r_i;
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
`ifdef TRI_ROOT_EXACT_EN
                        r_exact <= w_sum_eq;
`endif
                    end else begin
                        r_sum   <= w_sum_next;
                        r_i     <= w_i_next;
                        r_state <= S_CALC;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    // Unreachable encoding: recover to IDLE with outputs quiet.
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tri_root_hlsm.sv
// Directed self-checking bench for tri_root_hlsm (WIDTH=4).
module tb_tri_root_hlsm;

    logic       clk;
    logic       rst;
    logic       b;
    logic [3:0] t;
    logic [3:0] n_out;
    logic       busy;
    logic       done;
`ifdef TRI_ROOT_EXACT_EN
    logic       exact;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    tri_root_hlsm #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .b     (b),
        .t     (t),
        .n_out (n_out),
        .busy  (busy),
`ifdef TRI_ROOT_EXACT_EN
        .exact (exact),
`endif
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one start pulse and return the edge count (after the accepting edge) at which done appears.
    task automatic start_and_wait(input logic [3:0] tv, output int k_done, output bit seen);
        @(negedge clk);
        t = tv;
        b = 1'b1;
        @(posedge clk);
        #1;
        b = 1'b0;
        seen   = 1'b0;
        k_done = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen   = 1'b1;
                k_done = k;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b   = 1'b0;
        t   = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (n_out !== 4'd0) begin n_fail++; $display("FAIL reset_n_out: got %0d want 0", n_out); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
`ifdef TRI_ROOT_EXACT_EN
        n_checks++;
        if (exact !== 1'b0) begin n_fail++; $display("FAIL reset_exact: got %b want 0", exact); end
`endif
    endtask

    task automatic test_basic();
        logic [3:0] tv [5]   = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd15};
        logic [3:0] nexp [5] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd6};
        logic       xexp [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        int  k_done;
        bit  seen;
        for (int j = 0; j < 5; j++) begin
            start_and_wait(tv[j], k_done, seen);
            n_checks++;
            if (!seen) begin
                n_fail++;
                $display("FAIL basic_timeout t=%0d: done not seen within 40 cycles", tv[j]);
            end
            n_checks++;
            if (k_done + 1 !== int'(nexp[j]) + 2) begin
                n_fail++;
                $display("FAIL basic_latency t=%0d: got %0d want %0d", tv[j], k_done + 1, int'(nexp[j]) + 2);
            end
            n_checks++;
            if (n_out !== nexp[j]) begin
                n_fail++;
                $display("FAIL basic_n_out t=%0d: got %0d want %0d", tv[j], n_out, nexp[j]);
            end
`ifdef TRI_ROOT_EXACT_EN
            n_checks++;
            if (exact !== xexp[j]) begin
                n_fail++;
                $display("FAIL basic_exact t=%0d: got %b want %b", tv[j], exact, xexp[j]);
            end
`else
            if (xexp[j] === 1'bx) $display("unexpected table entry");
`endif
            @(posedge clk);
            #1;
            n_checks++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width t=%0d: done %b want 0", tv[j], done); end
            n_checks++;
            if (n_out !== nexp[j]) begin n_fail++; $display("FAIL basic_hold t=%0d: got %0d want %0d", tv[j], n_out, nexp[j]); end
        end
    endtask

    task automatic test_ignore_mid_calc();
        int pulses  = 0;
        int first_k = 0;
        @(negedge clk);
        t = 4'd9;
        b = 1'b1;
        @(posedge clk);
        #1;
        b = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 2) begin
                n_checks++;
                if (busy !== 1'b1) begin n_fail++; $display("FAIL ignore_busy: got %b want 1", busy); end
                t = 4'd0;
                b = 1'b1;
            end else begin
                b = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                if (first_k == 0) first_k = k;
            end
        end
        b = 1'b0;
        n_checks++;
        if (pulses !== 1) begin n_fail++; $display("FAIL ignore_pulses: got %0d want 1", pulses); end
        n_checks++;
        if (first_k !== 6) begin n_fail++; $display("FAIL ignore_latency: got edge %0d want 6", first_k); end
        n_checks++;
        if (n_out !== 4'd5) begin n_fail++; $display("FAIL ignore_n_out: got %0d want 5", n_out); end
    endtask

    task automatic test_reset_mid_calc();
        int pulses = 0;
        @(negedge clk);
        t = 4'd15;
        b = 1'b1;
        @(posedge clk);
        #1;
        b = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_checks++;
        if (n_out !== 4'd0) begin n_fail++; $display("FAIL rstmid_n_out: got %0d want 0", n_out); end
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin n_fail++; $display("FAIL rstmid_done: got %0d pulses want 0", pulses); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int prev_k = -1;
        @(negedge clk);
        t = 4'd1;
        b = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                n_checks++;
                if (n_out !== 4'd2) begin n_fail++; $display("FAIL b2b_n_out: got %0d want 2", n_out); end
                if (prev_k >= 0) begin
                    n_checks++;
                    if (k - prev_k !== 5) begin n_fail++; $display("FAIL b2b_period: got %0d want 5", k - prev_k); end
                end else begin
                    n_checks++;
                    if (k !== 4) begin n_fail++; $display("FAIL b2b_first: got edge %0d want 4", k); end
                end
                prev_k = k;
            end
        end
        b = 1'b0;
        n_checks++;
        if (pulses !== 6) begin n_fail++; $display("FAIL b2b_count: got %0d want 6", pulses); end
        repeat (10) @(posedge clk);
    endtask

    initial begin
        rst = 1'b1;
        b   = 1'b0;
        t   = 4'd0;
        test_reset();
        test_basic();
        test_ignore_mid_calc();
        test_reset_mid_calc();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
